// File: rtl/biriscv_fetch_ctrl.sv
// Fetch controller: issues 64-bit-aligned I-cache reads, tracks one outstanding request,
// handles redirects and hands instruction pairs to decode through a one-entry skid buffer.
module biriscv_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_accept_i,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i,
  input  logic [63:0] icache_inst_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic [1:0]  branch_priv_i,
  input  logic [31:0] next_pc_f_i,
  input  logic [1:0]  next_taken_f_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [1:0]  fetch_pred_branch_o,
  output logic        fetch_fault_fetch_o,
  output logic        fetch_fault_page_o,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic [1:0]  icache_priv_o,
  output logic [31:0] pc_f_o,
  output logic        pc_accept_o
);

  localparam logic [31:0] Nop = 32'h00000013;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [1:0]  pred_q, pred_d;
  logic [1:0]  priv_q, priv_d;
  logic        active_q, active_d;
  logic        drop_q, drop_d;

  logic        skid_valid_q, skid_valid_d;
  logic [63:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [1:0]  skid_pred_q, skid_pred_d;
  logic        skid_ff_q, skid_ff_d;
  logic        skid_fp_q, skid_fp_d;

  logic        live;
  logic        live_fault;
  logic [63:0] live_instr;
  logic [31:0] live_pc;

  assign live = icache_valid_i & active_q & ~drop_q & ~branch_request_i;

  // A request goes out when idle, or back-to-back with a response that is consumed or dropped.
  assign icache_rd_o = ~branch_request_i & ~skid_valid_q &
                       (~active_q | (icache_valid_i & (drop_q | fetch_accept_i)));
  assign pc_accept_o   = icache_rd_o & icache_accept_i;
  assign icache_pc_o   = {pc_f_q[31:3], 3'b000};
  assign icache_priv_o = priv_q;
  assign pc_f_o        = pc_f_q;

  // Fetch started mid-pair: slot0 precedes the target and becomes a NOP.
  assign live_fault = icache_error_i | icache_page_fault_i;
  assign live_instr = live_fault ? 64'b0 :
                      {icache_inst_i[63:32], pc_d_q[2] ? Nop : icache_inst_i[31:0]};
  assign live_pc    = {pc_d_q[31:3], 3'b000};

  always_comb begin
    if (skid_valid_q) begin
      fetch_instr_o       = skid_instr_q;
      fetch_pc_o          = skid_pc_q;
      fetch_pred_branch_o = skid_pred_q;
      fetch_fault_fetch_o = skid_ff_q;
      fetch_fault_page_o  = skid_fp_q;
    end else begin
      fetch_instr_o       = live_instr;
      fetch_pc_o          = live_pc;
      fetch_pred_branch_o = pred_q;
      fetch_fault_fetch_o = icache_error_i;
      fetch_fault_page_o  = icache_page_fault_i;
    end
  end

  assign fetch_valid_o = skid_valid_q | live;

  always_comb begin
    pc_f_d       = pc_f_q;
    pc_d_d       = pc_d_q;
    pred_d       = pred_q;
    priv_d       = priv_q;
    active_d     = active_q;
    drop_d       = drop_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_pred_d  = skid_pred_q;
    skid_ff_d    = skid_ff_q;
    skid_fp_d    = skid_fp_q;

    if (branch_request_i) begin
      pc_f_d       = branch_pc_i;
      priv_d       = branch_priv_i;
      skid_valid_d = 1'b0;
      if (active_q && !icache_valid_i) begin
        drop_d = 1'b1;
      end else if (active_q) begin
        active_d = 1'b0;
        drop_d   = 1'b0;
      end
    end else begin
      if (pc_accept_o) begin
        active_d = 1'b1;
        drop_d   = 1'b0;
        pc_d_d   = pc_f_q;
        pred_d   = next_taken_f_i;
        pc_f_d   = next_pc_f_i;
      end else if (icache_valid_i && active_q) begin
        active_d = 1'b0;
        drop_d   = 1'b0;
      end

      if (live && !fetch_accept_i) begin
        skid_valid_d = 1'b1;
        skid_instr_d = live_instr;
        skid_pc_d    = live_pc;
        skid_pred_d  = pred_q;
        skid_ff_d    = icache_error_i;
        skid_fp_d    = icache_page_fault_i;
      end else if (skid_valid_q && fetch_accept_i) begin
        skid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_f_q       <= RESET_PC;
      pc_d_q       <= 32'b0;
      pred_q       <= 2'b0;
      priv_q       <= 2'b11;
      active_q     <= 1'b0;
      drop_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 64'b0;
      skid_pc_q    <= 32'b0;
      skid_pred_q  <= 2'b0;
      skid_ff_q    <= 1'b0;
      skid_fp_q    <= 1'b0;
    end else begin
      pc_f_q       <= pc_f_d;
      pc_d_q       <= pc_d_d;
      pred_q       <= pred_d;
      priv_q       <= priv_d;
      active_q     <= active_d;
      drop_q       <= drop_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_pred_q  <= skid_pred_d;
      skid_ff_q    <= skid_ff_d;
      skid_fp_q    <= skid_fp_d;
    end
  end

endmodule
